dealer_card_server: RTL and testbench

//  Dealer side of the table/card-return interface: starts a round, deals a hand, serves

---
 rtl/poker_pkg.sv | 24 ++
 rtl/card_lfsr.sv | 24 ++
 rtl/dealer_card_server.sv | 147 ++++++++++++++
 tb/tb_dealer_card_server.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/poker_pkg.sv
// Card, command and FSM state types shared by the dealer and its shuffle source.
package poker_pkg;

  typedef struct packed {
    logic [1:0] suit;
    logic [3:0] rank;
  } card_t;

  typedef enum logic [1:0] {CMD_STAND, CMD_FOLD, CMD_DRAW, CMD_RSVD} cmd_e;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_PICK, S_PRESENT, S_GAP, S_WAIT_CMD, S_ACK_WAIT, S_OVER
  } state_e;

  localparam logic [5:0] DECK_SIZE = 6'd52;
  localparam logic [3:0] RANK_MIN  = 4'd1;
  localparam logic [3:0] RANK_MAX  = 4'd13;
  localparam logic [1:0] SUIT_MAX  = 2'd3;

  function automatic logic card_is_valid(input card_t c);
    return (c.rank >= RANK_MIN) && (c.rank <= RANK_MAX);
  endfunction

endpackage

// File: rtl/card_lfsr.sv
// Shuffle source: 6-bit maximal LFSR (x^6+x^5+1). value/valid describe the code the
// next step lands on, so a PICK cycle that steps onto a valid card can present it directly.
module card_lfsr import poker_pkg::*; (
  input  logic       clk,
  input  logic       step,
  input  logic       load,
  input  logic [5:0] seed,
  output card_t      value,
  output logic       valid
);

  logic [5:0] r;
  logic [5:0] nxt;

  assign nxt   = {r[4:0], r[5] ^ r[4]};
  assign value = card_t'(nxt);
  assign valid = card_is_valid(value);

  always_ff @(posedge clk) begin
    if (load)      r <= seed;
    else if (step) r <= nxt;
  end

endmodule

// File: rtl/dealer_card_server.sv
// Dealer side of the card-return interface: starts rounds, deals cards from the LFSR
// deck, serves STAND/FOLD/DRAW commands with a delayed ack, and ends rounds.
module dealer_card_server import poker_pkg::*; #(
  parameter int         CARDS_PER_HAND = 5,
  parameter int         CARD_GAP       = 2,
  parameter int         ACK_LAT        = 1,
  parameter logic [5:0] SEED           = 6'h2D
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_start,
  output logic       tbl_game_start,
  output logic [7:0] cr_rdata,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_code,
  input  logic [2:0] cmd_arg,
  output logic       cr_ack,
  output logic       tbl_game_over,
  output logic       deck_empty,
  output logic       cmd_err,
  output logic [2:0] state
);

  localparam logic [7:0] GAP_INIT = 8'(CARD_GAP - 1);
  localparam logic [7:0] ACK_INIT = 8'(ACK_LAT - 1);
  localparam logic [2:0] HAND     = 3'(CARDS_PER_HAND);

  state_e     st;
  logic [5:0] dealt_cnt;
  logic [2:0] remaining;
  logic [2:0] arg_q;
  logic [7:0] gap_cnt;
  logic [7:0] ack_cnt;
  cmd_e       cmd_q;
  card_t      pick;
  logic       pick_ok;
  logic       pulse_nxt;

  card_lfsr u_lfsr (
    .clk   (clk),
    .step  (st == S_PICK),
    .load  (rst),
    .seed  (SEED),
    .value (pick),
    .valid (pick_ok)
  );

  assign state = st;

  // A stray command yields its error pulse to any protocol pulse due in the same cycle.
  always_comb begin
    pulse_nxt = 1'b0;
    case (st)
      S_IDLE:     pulse_nxt = game_start;
      S_ACK_WAIT: pulse_nxt = (ack_cnt == 8'd1) || ((ack_cnt == 8'd0) && (cmd_q != CMD_DRAW));
      default:    pulse_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st             <= S_IDLE;
      tbl_game_start <= 1'b0;
      tbl_game_over  <= 1'b0;
      cr_ack         <= 1'b0;
      cmd_err        <= 1'b0;
      cr_rdata       <= 8'h00;
      deck_empty     <= 1'b0;
      dealt_cnt      <= 6'd0;
      remaining      <= 3'd0;
      arg_q          <= 3'd0;
      gap_cnt        <= 8'd0;
      ack_cnt        <= 8'd0;
      cmd_q          <= CMD_STAND;
    end else begin
      tbl_game_start <= 1'b0;
      tbl_game_over  <= 1'b0;
      cr_ack         <= 1'b0;
      cmd_err        <= 1'b0;
      cr_rdata       <= 8'h00;
      if (cmd_valid && (st != S_WAIT_CMD) && !pulse_nxt) cmd_err <= 1'b1;

      case (st)
        S_IDLE: if (game_start) begin
          st             <= S_START;
          tbl_game_start <= 1'b1;
          dealt_cnt      <= 6'd0;
          deck_empty     <= 1'b0;
          remaining      <= HAND;
        end
        S_START: begin
          st      <= S_GAP;
          gap_cnt <= GAP_INIT;
        end
        S_PICK: if (pick_ok) begin
          st        <= S_PRESENT;
          cr_rdata  <= {2'b00, pick};
          dealt_cnt <= dealt_cnt + 6'd1;
          remaining <= remaining - 3'd1;
        end
        S_PRESENT: begin
          st      <= S_GAP;
          gap_cnt <= GAP_INIT;
        end
        S_GAP: begin
          if (gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;
          else if (remaining == 3'd0) st <= S_WAIT_CMD;
          else if (dealt_cnt == DECK_SIZE) begin
            deck_empty <= 1'b1;
            remaining  <= 3'd0;
            st         <= S_WAIT_CMD;
          end else st <= S_PICK;
        end
        S_WAIT_CMD: if (cmd_valid) begin
          if (cmd_code == CMD_RSVD) cmd_err <= 1'b1;
          else begin
            cmd_q   <= cmd_e'(cmd_code);
            arg_q   <= cmd_arg;
            ack_cnt <= ACK_INIT;
            cr_ack  <= (ACK_LAT == 1);
            st      <= S_ACK_WAIT;
          end
        end
        S_ACK_WAIT: begin
          // ack is high during the last ACK_WAIT cycle; dispatch happens on that cycle
          if (ack_cnt != 8'd0) begin
            ack_cnt <= ack_cnt - 8'd1;
            cr_ack  <= (ack_cnt == 8'd1);
          end else if (cmd_q == CMD_DRAW) begin
            if (arg_q == 3'd0) st <= S_WAIT_CMD;
            else begin
              remaining <= arg_q;
              gap_cnt   <= GAP_INIT;
              st        <= S_GAP;
            end
          end else begin
            tbl_game_over <= 1'b1;
            st            <= S_OVER;
          end
        end
        S_OVER:  st <= S_IDLE;
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dealer_card_server.sv
// Directed bench for dealer_card_server with a per-cycle deck-order model and round tracker.
module tb_dealer_card_server;
  import poker_pkg::*;

  localparam int         CPH  = 5;
  localparam int         GAP  = 2;
  localparam int         ACKL = 1;
  localparam logic [5:0] SEED = 6'h2D;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       game_start = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_code = 2'd0;
  logic [2:0] cmd_arg = 3'd0;
  logic       tbl_game_start, cr_ack, tbl_game_over, deck_empty, cmd_err;
  logic [7:0] cr_rdata;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  logic [5:0] ord [52];   // order of valid cards produced by the LFSR after SEED (period 52)
  logic [7:0] log_c [3];
  bit         seen [64];
  int         pos, round_cards, run_zero;

  always #5 clk = ~clk;

  dealer_card_server #(.CARDS_PER_HAND(CPH), .CARD_GAP(GAP), .ACK_LAT(ACKL), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .game_start(game_start), .tbl_game_start(tbl_game_start),
    .cr_rdata(cr_rdata), .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_arg(cmd_arg),
    .cr_ack(cr_ack), .tbl_game_over(tbl_game_over), .deck_empty(deck_empty),
    .cmd_err(cmd_err), .state(state)
  );

  function automatic logic [5:0] lfsr_step(input logic [5:0] v);
    return {v[4:0], v[5] ^ v[4]};
  endfunction

  function automatic bit is_card(input logic [5:0] v);
    return (v[3:0] >= 4'd1) && (v[3:0] <= 4'd13);
  endfunction

  task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(name, act === exp, act, exp);
  endtask

  function automatic int seen_count();
    int n = 0;
    foreach (seen[i]) if (seen[i]) n++;
    return n;
  endfunction

  // Advance one cycle, sample 1 time unit after the edge, and check against the model.
  task automatic tick();
    int npulse;
    @(posedge clk); #1;
    npulse = int'(tbl_game_start) + int'(cr_ack) + int'(tbl_game_over) + int'(cmd_err);
    chk("pulse_excl", npulse <= 1, 32'(npulse), 32'd1);
    if (rst) begin
      pos = 0; round_cards = 0; run_zero = 0;
      seen = '{default: 1'b0};
      chk_eq("rst_outputs",
             32'({tbl_game_start, cr_ack, tbl_game_over, deck_empty, cmd_err, cr_rdata, state}), 32'd0);
    end else begin
      if (tbl_game_start) begin
        round_cards = 0; run_zero = 0;
        seen = '{default: 1'b0};
      end
      if (cr_rdata != 8'h00) begin
        chk_eq("card_seq", 32'(cr_rdata), 32'({2'b00, ord[pos % 52]}));
        chk("card_fmt", cr_rdata[7:6] == 2'b00 && is_card(cr_rdata[5:0]), 32'(cr_rdata), 32'(cr_rdata & 8'h3F));
        chk("card_dup", !seen[cr_rdata[5:0]], 32'(cr_rdata), 32'd0);
        chk("card_gap", run_zero >= GAP, 32'(run_zero), 32'(GAP));
        chk("deck_bound", round_cards < 52, 32'(round_cards), 32'd51);
        if (pos < 3) log_c[pos] = cr_rdata;
        seen[cr_rdata[5:0]] = 1'b1;
        round_cards++; pos++; run_zero = 0;
      end else run_zero++;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    int n = 0;
    while (state !== s && n < 400) begin tick(); n++; end
    chk(name, state === s, 32'(state), 32'(s));
  endtask

  task automatic send(input logic [1:0] code, input logic [2:0] arg);
    cmd_valid = 1'b1; cmd_code = code; cmd_arg = arg;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    logic [5:0] v;
    int n;
    v = SEED;
    for (int k = 0; k < 52; k++) begin
      v = lfsr_step(v);
      while (!is_card(v)) v = lfsr_step(v);
      ord[k] = v;
    end
    chk_eq("model_pin", 32'({ord[0], ord[1], ord[2]}), 32'({6'h1B, 6'h37, 6'h1D}));

    // reset and idle
    repeat (3) tick();
    chk_eq("reset_state", 32'(state), 32'(S_IDLE));
    rst = 1'b0;
    repeat (4) tick();
    chk_eq("idle_quiet", 32'({state, cr_rdata, tbl_game_start, cr_ack, cmd_err}), 32'd0);

    // round 1: five cards
    game_start = 1'b1;
    tick();
    game_start = 1'b0;
    chk_eq("start_pulse", 32'(tbl_game_start), 32'd1);
    chk_eq("start_state", 32'(state), 32'(S_START));
    wait_state(S_WAIT_CMD, "deal_done");
    chk_eq("hand_size", 32'(round_cards), 32'(CPH));
    chk_eq("first_cards", 32'({log_c[0], log_c[1], log_c[2]}), 32'({8'h1B, 8'h37, 8'h1D}));

    // reserved command: error, no ack
    send(2'b11, 3'd0);
    chk_eq("rsvd_err", 32'({cmd_err, cr_ack}), 32'b10);
    chk_eq("rsvd_stay", 32'(state), 32'(S_WAIT_CMD));
    tick();
    chk_eq("rsvd_err_clr", 32'(cmd_err), 32'd0);

    // DRAW 3 with a stray command injected mid-deal
    send(CMD_DRAW, 3'd3);
    chk_eq("draw3_ack", 32'(cr_ack), 32'd1);
    repeat (2) tick();
    send(CMD_STAND, 3'd0);
    chk_eq("busy_err", 32'({cmd_err, cr_ack}), 32'b10);
    wait_state(S_WAIT_CMD, "draw3_done");
    chk_eq("draw3_cards", 32'(round_cards), 32'(CPH + 3));

    // DRAW 0: ack only
    send(CMD_DRAW, 3'd0);
    chk_eq("draw0_ack", 32'(cr_ack), 32'd1);
    tick();
    chk_eq("draw0_stay", 32'({state, 5'(round_cards)}), 32'({S_WAIT_CMD, 5'(CPH + 3)}));

    // STAND: ack, then game_over, then idle
    send(CMD_STAND, 3'd0);
    chk_eq("stand_ack", 32'({cr_ack, tbl_game_over}), 32'b10);
    tick();
    chk_eq("stand_over", 32'({cr_ack, tbl_game_over}), 32'b01);
    tick();
    chk_eq("stand_idle", 32'({state, tbl_game_over}), 32'({S_IDLE, 1'b0}));

    // round 2: continues the deck sequence; then drain the deck
    game_start = 1'b1;
    tick();
    game_start = 1'b0;
    chk_eq("start2_pulse", 32'(tbl_game_start), 32'd1);
    wait_state(S_WAIT_CMD, "deal2_done");
    chk_eq("deck_not_empty", 32'(deck_empty), 32'd0);
    n = 0;
    while (!deck_empty && n < 8) begin
      send(CMD_DRAW, 3'd7);
      chk_eq("draw7_ack", 32'(cr_ack), 32'd1);
      wait_state(S_WAIT_CMD, "draw7_done");
      n++;
    end
    chk_eq("deck_empty", 32'(deck_empty), 32'd1);
    chk_eq("deck_cards", 32'(round_cards), 32'd52);
    chk_eq("deck_unique", 32'(seen_count()), 32'd52);
    send(CMD_DRAW, 3'd7);
    wait_state(S_WAIT_CMD, "empty_draw_done");
    chk_eq("empty_no_cards", 32'({deck_empty, 6'(round_cards)}), 32'({1'b1, 6'd52}));
    send(CMD_FOLD, 3'd0);
    wait_state(S_IDLE, "fold_idle");

    // round 3: deck_empty clears; reset while a card is presented
    game_start = 1'b1;
    tick();
    game_start = 1'b0;
    chk_eq("start3_clear", 32'({tbl_game_start, deck_empty}), 32'b10);
    n = 0;
    while (cr_rdata == 8'h00 && n < 60) begin tick(); n++; end
    chk("card_before_rst", cr_rdata != 8'h00, 32'(cr_rdata), 32'd1);
    rst = 1'b1;
    tick();
    chk_eq("rst_mid_round", 32'({state, cr_rdata}), 32'({S_IDLE, 8'h00}));
    rst = 1'b0;
    repeat (3) tick();
    chk_eq("post_rst_quiet", 32'({state, cr_ack, tbl_game_over, cr_rdata}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
